// File: rtl/packet_pkg.sv
// Types and constants shared by the packet packer and unpacker.
package packet_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      SYNC    = 3'd1,
      PAD_PRE = 3'd2,
      PAYLOAD = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   localparam int SYNC_SYMS = 4;
   localparam int PAD_SYMS  = 4;

   localparam shortint DEF_P0_I = 16'sd32767;
   localparam shortint DEF_P0_Q = 16'sd0;
   localparam shortint DEF_P1_I = 16'sd0;
   localparam shortint DEF_P1_Q = 16'sd32767;

   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
   } iq_sample_t;

   function automatic iq_sample_t make_iq(input shortint i_val, input shortint q_val);
      iq_sample_t s;
      s.i = i_val;
      s.q = q_val;
      return s;
   endfunction

endpackage

// File: rtl/packet_sync_detector.sv
// Run-length matcher for the alternating P0/P1 preamble; pulses o_sync_done
// on the final beat of the last sync symbol.
module packet_sync_detector
   import packet_pkg::*;
#(
   parameter int          NUM_SAMPLES = 100,
   parameter logic [31:0] P0          = 32'h7FFF_0000,
   parameter logic [31:0] P1          = 32'h0000_7FFF
) (
   input  logic        i_clk,
   input  logic        i_rst_b,
   input  logic        i_hunt,
   input  logic        i_sync,
   input  logic        i_beat,
   input  logic [31:0] i_sample,
   output logic        o_lock,
   output logic        o_lost,
   output logic        o_sync_done
);

   localparam int RW = $clog2(NUM_SAMPLES) + 1;
   localparam int SW = $clog2(SYNC_SYMS) + 1;
   localparam logic [RW-1:0] RUN_LAST = RW'(NUM_SAMPLES - 1);
   localparam logic [SW-1:0] SYM_LAST = SW'(SYNC_SYMS - 1);

   logic [RW-1:0] r_run;
   logic [SW-1:0] r_sym_idx;
   logic          w_is_p0;
   logic          w_match;
   logic          w_run_end;

   // Even symbols carry P0, odd symbols P1.
   assign w_is_p0     = (i_sample == P0);
   assign w_match     = (i_sample == (r_sym_idx[0] ? P1 : P0));
   assign w_run_end   = (r_run == RUN_LAST);

   assign o_lock      = i_hunt && i_beat && w_is_p0;
   assign o_lost      = i_sync && i_beat && !w_match && !w_is_p0;
   assign o_sync_done = i_sync && i_beat && w_match && w_run_end && (r_sym_idx == SYM_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_b) begin
         r_run     <= '0;
         r_sym_idx <= '0;
      end else if (o_lock) begin
         r_run     <= RW'(1);
         r_sym_idx <= '0;
      end else if (i_sync && i_beat) begin
         if (w_match) begin
            if (w_run_end) begin
               r_run     <= '0;
               r_sym_idx <= r_sym_idx + SW'(1);
            end else begin
               r_run <= r_run + RW'(1);
            end
         end else if (w_is_p0) begin
            r_run     <= RW'(1);
            r_sym_idx <= '0;
         end else begin
            r_run     <= '0;
            r_sym_idx <= '0;
         end
      end
   end

endmodule

// File: rtl/packet_unpacker_module.sv
// Receive-side unpacker: locks on the sync preamble, skips the pad, samples
// one point per payload symbol and replays the words as one AXIS packet.
//   state   | meaning
//   HUNT    | discard samples until a P0 beat
//   SYNC    | matching the 4-symbol alternating preamble
//   PAD_PRE | skipping the pre-pad symbols
//   PAYLOAD | capturing one sample per payload symbol
//   DRAIN   | emitting captured words, input stalled
module packet_unpacker_module
   import packet_pkg::*;
#(
   parameter int      C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int      C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int      NUM_SAMPLES            = 100,
   parameter int      NUM_DATA               = 4,
   parameter int      CAPTURE_IDX            = NUM_SAMPLES / 2,
   parameter shortint p0_I                   = DEF_P0_I,
   parameter shortint p0_Q                   = DEF_P0_Q,
   parameter shortint p1_I                   = DEF_P1_I,
   parameter shortint p1_Q                   = DEF_P1_Q
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   output logic [2:0]                            led,
   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic [31:0]                           pkt_count
);

   localparam logic [31:0] P0 = make_iq(p0_I, p0_Q);
   localparam logic [31:0] P1 = make_iq(p1_I, p1_Q);
   localparam int RW        = $clog2(NUM_SAMPLES) + 1;
   localparam int DW        = $clog2(NUM_DATA) + 1;
   localparam int PW        = $clog2(PAD_SYMS * NUM_SAMPLES) + 1;
   localparam int BUF_DEPTH = 1 << DW;
   localparam logic [RW-1:0] SAMP_LAST = RW'(NUM_SAMPLES - 1);
   localparam logic [RW-1:0] CAP       = RW'(CAPTURE_IDX);
   localparam logic [DW-1:0] DATA_LAST = DW'(NUM_DATA - 1);
   localparam logic [PW-1:0] PAD_LAST  = PW'(PAD_SYMS * NUM_SAMPLES - 1);
   localparam bit            BYPASS    = (NUM_DATA == 1) && (CAPTURE_IDX == NUM_SAMPLES - 1);

   state_t                            r_state, w_state_nxt;
   logic [PW-1:0]                     r_pad_cnt;
   logic [RW-1:0]                     r_samp;
   logic [DW-1:0]                     r_data_idx;
   logic [DW-1:0]                     r_out_idx;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic                              r_s_tready;
   logic                              r_m_tvalid;
   logic                              r_m_tlast;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_m_tdata;
   logic [31:0]                       r_pkt_count;

   logic                              w_beat, w_m_hs, w_sym_end;
   logic                              w_lock, w_lost, w_sync_done;
   logic                              w_pad_done, w_pay_done, w_last_hs;
   logic [DW-1:0]                     w_next_idx;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] w_first_word;
   logic                              w_unused_in;

   assign w_unused_in  = ^{s00_axis_tstrb, s00_axis_tlast};
   assign w_beat       = s00_axis_tvalid && r_s_tready;
   assign w_m_hs       = r_m_tvalid && m00_axis_tready;
   assign w_sym_end    = (r_samp == SAMP_LAST);
   assign w_pad_done   = (r_state == PAD_PRE) && w_beat && (r_pad_cnt == '0);
   assign w_pay_done   = (r_state == PAYLOAD) && w_beat && w_sym_end && (r_data_idx == DATA_LAST);
   assign w_last_hs    = (r_state == DRAIN) && w_m_hs && (r_out_idx == DATA_LAST);
   assign w_next_idx   = r_out_idx + DW'(1);
   // With one word captured on the final sample, buf[0] is written on the same edge.
   assign w_first_word = BYPASS ? s00_axis_tdata : r_buf[0];

   packet_sync_detector #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .P0          (P0),
      .P1          (P1)
   ) u_sync (
      .i_clk       (s00_axis_aclk),
      .i_rst_b     (s00_axis_aresetn),
      .i_hunt      (r_state == HUNT),
      .i_sync      (r_state == SYNC),
      .i_beat      (w_beat),
      .i_sample    (s00_axis_tdata[31:0]),
      .o_lock      (w_lock),
      .o_lost      (w_lost),
      .o_sync_done (w_sync_done)
   );

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) r_state <= HUNT;
      else                   r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HUNT:    if (w_lock) w_state_nxt = SYNC;
         SYNC:    if (w_sync_done) w_state_nxt = PAD_PRE;
                  else if (w_lost) w_state_nxt = HUNT;
         PAD_PRE: if (w_pad_done) w_state_nxt = PAYLOAD;
         PAYLOAD: if (w_pay_done) w_state_nxt = DRAIN;
         DRAIN:   if (w_last_hs) w_state_nxt = HUNT;
         default: w_state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (r_state == PAYLOAD && w_beat && r_samp == CAP) r_buf[r_data_idx] <= s00_axis_tdata;
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         r_pad_cnt   <= '0;
         r_samp      <= '0;
         r_data_idx  <= '0;
         r_out_idx   <= '0;
         r_s_tready  <= 1'b1;
         r_m_tvalid  <= 1'b0;
         r_m_tlast   <= 1'b0;
         r_m_tdata   <= '0;
         r_pkt_count <= '0;
      end else begin
         case (r_state)
            SYNC: if (w_sync_done) r_pad_cnt <= PAD_LAST;
            PAD_PRE: if (w_beat) begin
               if (r_pad_cnt == '0) begin
                  r_samp     <= '0;
                  r_data_idx <= '0;
               end else begin
                  r_pad_cnt <= r_pad_cnt - PW'(1);
               end
            end
            PAYLOAD: if (w_beat) begin
               if (w_sym_end) begin
                  r_samp <= '0;
                  if (r_data_idx == DATA_LAST) begin
                     r_s_tready <= 1'b0;
                     r_m_tvalid <= 1'b1;
                     r_m_tdata  <= w_first_word;
                     r_m_tlast  <= (NUM_DATA == 1);
                     r_out_idx  <= '0;
                  end else begin
                     r_data_idx <= r_data_idx + DW'(1);
                  end
               end else begin
                  r_samp <= r_samp + RW'(1);
               end
            end
            DRAIN: if (w_m_hs) begin
               if (r_out_idx == DATA_LAST) begin
                  r_m_tvalid  <= 1'b0;
                  r_m_tlast   <= 1'b0;
                  r_s_tready  <= 1'b1;
                  r_out_idx   <= '0;
                  r_pkt_count <= r_pkt_count + 32'd1;
               end else begin
                  r_out_idx <= w_next_idx;
                  r_m_tdata <= r_buf[w_next_idx];
                  r_m_tlast <= (w_next_idx == DATA_LAST);
               end
            end
            default: ;
         endcase
      end
   end

   assign led             = r_state;
   assign s00_axis_tready = r_s_tready;
   assign m00_axis_tvalid = r_m_tvalid;
   assign m00_axis_tlast  = r_m_tlast;
   assign m00_axis_tdata  = r_m_tdata;
   assign m00_axis_tstrb  = '1;
   assign pkt_count       = r_pkt_count;

endmodule

// File: tb/tb_packet_unpacker_module.sv
// Scoreboard bench for packet_unpacker_module with 4 samples/symbol, 4 words.
module tb_packet_unpacker_module;
   localparam int NS  = 4;
   localparam int ND  = 4;
   localparam int CAP = 2;
   localparam logic [31:0] P0 = 32'h7FFF_0000;
   localparam logic [31:0] P1 = 32'h0000_7FFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  led;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] s_tdata = '0;
   logic        m_tready = 1'b1;
   logic        m_tvalid;
   logic        m_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic [31:0] pkt_count;

   always #5 clk = ~clk;

   packet_unpacker_module #(
      .NUM_SAMPLES (NS),
      .NUM_DATA    (ND),
      .CAPTURE_IDX (CAP)
   ) dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .led              (led),
      .s00_axis_tvalid  (s_tvalid),
      .s00_axis_tready  (s_tready),
      .s00_axis_tdata   (s_tdata),
      .s00_axis_tstrb   (4'hF),
      .s00_axis_tlast   (1'b0),
      .m00_axis_tready  (m_tready),
      .m00_axis_tvalid  (m_tvalid),
      .m00_axis_tlast   (m_tlast),
      .m00_axis_tdata   (m_tdata),
      .m00_axis_tstrb   (m_tstrb),
      .pkt_count        (pkt_count)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int hs_count = 0;
   int first_valid_cyc = -1;
   int last_beat_cyc = 0;
   int last_pay_cyc = 0;
   int exp_pkts = 0;
   logic        prev_valid = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_exp;
   logic [31:0] words [ND] = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4};

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every accepted word is popped against the scoreboard.
   always @(negedge clk) begin
      if (m_tvalid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = m_tvalid;
      if (m_tvalid) begin
         vectors++;
         if (led !== 3'd4) begin
            miscompares++;
            $display("FAIL valid_outside_drain: led=%0d, required 4", led);
         end
      end
      if (m_tvalid && m_tready) begin
         vectors++;
         hs_count++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL out_unexpected: got data=%h last=%b, required no output", m_tdata, m_tlast);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== mon_exp) begin
               miscompares++;
               $display("FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                        m_tlast, m_tdata, mon_exp[32], mon_exp[31:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   task automatic send_sample(input logic [31:0] d, input bit gaps);
      int budget;
      bit accepted;
      if (gaps) begin
         while ($urandom_range(1) == 1) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
         end
      end
      s_tvalid = 1'b1;
      s_tdata  = d;
      accepted = 1'b0;
      budget   = 0;
      while (!accepted && budget < 200) begin
         @(negedge clk);
         accepted = s_tready;
         @(posedge clk); #1;
         budget++;
      end
      s_tvalid = 1'b0;
      last_beat_cyc = cyc;
      if (!accepted) begin
         vectors++;
         miscompares++;
         $display("FAIL in_accept_timeout: tready=%b, required 1 within 200 cycles", s_tready);
      end
   endtask

   task automatic send_const(input logic [31:0] d, input int n, input bit gaps);
      for (int i = 0; i < n; i++) send_sample(d, gaps);
   endtask

   task automatic send_sync(input bit gaps);
      for (int s = 0; s < 4; s++) send_const((s % 2 == 0) ? P0 : P1, NS, gaps);
   endtask

   task automatic send_payload(input int nsyms, input bit gaps, input bit push);
      for (int s = 0; s < nsyms; s++) begin
         if (push) exp_q.push_back({(s == ND - 1), words[s]});
         for (int k = 0; k < NS; k++)
            send_sample((k == CAP) ? words[s] : (32'h5A5A_0000 | (s << 8) | k), gaps);
      end
      last_pay_cyc = last_beat_cyc;
   endtask

   task automatic send_frame(input bit gaps, input bit push);
      send_sync(gaps);
      send_const(32'h0, 4 * NS, gaps);
      send_payload(ND, gaps, push);
      send_const(32'h0, 4 * NS, gaps);
   endtask

   task automatic wait_drain();
      int budget = 0;
      while ((exp_q.size() != 0 || m_tvalid) && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      vectors++;
      if (exp_q.size() != 0 || m_tvalid) begin
         miscompares++;
         $display("FAIL drain_timeout: pending=%0d tvalid=%b, required 0 and 0", exp_q.size(), m_tvalid);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic check_pkts(input string name);
      vectors++;
      if (pkt_count !== 32'(exp_pkts)) begin
         miscompares++;
         $display("FAIL %s pkt_count: got %0d, required %0d", name, pkt_count, exp_pkts);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors += 7;
      if (led !== 3'd0)      begin miscompares++; $display("FAIL rst_led: got %0d, required 0", led); end
      if (s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_s_tready: got %b, required 1", s_tready); end
      if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b, required 0", m_tvalid); end
      if (m_tlast !== 1'b0)  begin miscompares++; $display("FAIL rst_m_tlast: got %b, required 0", m_tlast); end
      if (m_tdata !== 32'h0) begin miscompares++; $display("FAIL rst_m_tdata: got %h, required 0", m_tdata); end
      if (pkt_count !== 32'h0) begin miscompares++; $display("FAIL rst_pkt_count: got %0d, required 0", pkt_count); end
      if (m_tstrb !== 4'hF)  begin miscompares++; $display("FAIL rst_m_tstrb: got %h, required f", m_tstrb); end
      @(posedge clk); #1;
   endtask

   task automatic test_clean_frame();
      int hs0 = hs_count;
      first_valid_cyc = -1;
      exp_pkts++;
      send_frame(1'b0, 1'b1);
      wait_drain();
      check_pkts("clean");
      vectors += 2;
      if (first_valid_cyc != last_pay_cyc) begin
         miscompares++;
         $display("FAIL clean_latency: tvalid rose at cycle %0d, required %0d", first_valid_cyc, last_pay_cyc);
      end
      if (hs_count - hs0 != ND) begin
         miscompares++;
         $display("FAIL clean_beats: got %0d, required %0d", hs_count - hs0, ND);
      end
   endtask

   task automatic test_broken_sync();
      send_const(P0, 4, 1'b0);
      send_const(P1, 2, 1'b0);
      send_sample(32'h0, 1'b0);
      @(negedge clk);
      vectors++;
      if (led !== 3'd0) begin
         miscompares++;
         $display("FAIL broken_sync_state: led=%0d, required 0", led);
      end
      @(posedge clk); #1;
      send_const(32'h0, 8, 1'b0);
      check_pkts("broken_sync");
      exp_pkts++;
      send_frame(1'b0, 1'b1);
      wait_drain();
      check_pkts("after_broken");
   endtask

   task automatic test_resync();
      send_const(P0, 4, 1'b0);
      send_const(P1, 2, 1'b0);
      exp_pkts++;
      send_frame(1'b0, 1'b1);
      wait_drain();
      check_pkts("resync");
   endtask

   task automatic test_backpressure();
      int hs0 = hs_count;
      int budget = 0;
      exp_pkts++;
      fork
         send_frame(1'b0, 1'b1);
         begin
            while (hs_count - hs0 < 2 && budget < 400) begin
               @(posedge clk); #1;
               budget++;
            end
            m_tready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               vectors += 4;
               if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL bp_tvalid: got %b, required 1", m_tvalid); end
               if (m_tdata !== words[2]) begin miscompares++; $display("FAIL bp_hold_data: got %h, required %h", m_tdata, words[2]); end
               if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL bp_hold_last: got %b, required 0", m_tlast); end
               if (s_tready !== 1'b0) begin miscompares++; $display("FAIL bp_s_tready: got %b, required 0", s_tready); end
               @(posedge clk); #1;
            end
            m_tready = 1'b1;
            budget = 0;
            @(negedge clk);
            while (m_tvalid && budget < 20) begin
               vectors++;
               if (s_tready !== 1'b0) begin miscompares++; $display("FAIL bp_s_tready_tail: got %b, required 0", s_tready); end
               @(negedge clk);
               budget++;
            end
            vectors++;
            if (s_tready !== 1'b1) begin miscompares++; $display("FAIL bp_s_tready_after: got %b, required 1", s_tready); end
         end
      join
      wait_drain();
      check_pkts("backpressure");
   endtask

   task automatic test_gaps();
      exp_pkts++;
      send_frame(1'b1, 1'b1);
      wait_drain();
      check_pkts("gaps");
   endtask

   task automatic test_reset_mid_payload();
      send_sync(1'b0);
      send_const(32'h0, 4 * NS, 1'b0);
      send_payload(2, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_pkts = 0;
      test_reset();
      send_payload(ND, 1'b0, 1'b0);
      send_const(32'h0, 4 * NS, 1'b0);
      check_pkts("mid_reset_abandon");
      exp_pkts++;
      send_frame(1'b0, 1'b1);
      wait_drain();
      check_pkts("after_mid_reset");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_clean_frame();
      test_broken_sync();
      test_resync();
      test_backpressure();
      test_gaps();
      test_reset_mid_payload();
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
